// File: rtl/tx_lane_scheduler.sv
// Serializer byte-slot scheduler: COM training, then round-robin burst-limited arbitration; bytes load on slot boundaries and hold 8 cycles.
// Requesters wait for a one-cycle req_ready pulse. Optional TX_STATS_EN adds a saturating transmitted-byte counter.
module tx_lane_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int SYNC_BYTES = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                   clk_32f,
  input  logic                   reset_L,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             data_out,
  output logic                   valid_out,
  output logic [2:0]             grant_id,
  output logic                   link_up,
  output logic [15:0]            tx_byte_count
);

  typedef enum logic [1:0] {SYNC, IDLE, BURST} state_t;

  state_t      state, state_nxt;
  logic [2:0]  slot_cnt;
  logic [3:0]  sync_cnt, sync_nxt;
  logic [2:0]  last_grant, last_nxt;
  logic [3:0]  burst_cnt, burst_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt;
  logic [2:0]  grant_nxt;
  logic        link_nxt;
  logic        boundary;
  logic [7:0]  vld_pad;
  logic [63:0] data_pad;
  logic        win_vld;
  logic [2:0]  win_id;
  logic [3:0]  idx;
  logic        take_vld;
  logic [2:0]  take_id;

  assign boundary = (slot_cnt == 3'd7);
  assign vld_pad  = 8'(req_valid);
  assign data_pad = 64'(req_data);

  // Rotating search starting after last_grant, so the current holder is examined last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 3'd0;
    idx     = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!win_vld && vld_pad[idx[2:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sync_nxt  = sync_cnt;
    last_nxt  = last_grant;
    burst_nxt = burst_cnt;
    data_nxt  = data_out;
    valid_nxt = valid_out;
    grant_nxt = grant_id;
    link_nxt  = link_up;
    take_vld  = 1'b0;
    take_id   = win_id;
    if (boundary) begin
      case (state)
        SYNC: begin
          data_nxt  = 8'hBC;
          valid_nxt = 1'b0;
          sync_nxt  = sync_cnt + 4'd1;
          if (sync_cnt == 4'(SYNC_BYTES - 1)) begin
            state_nxt = IDLE;
            link_nxt  = 1'b1;
          end
        end
        IDLE, BURST: begin
          if (state == BURST && vld_pad[grant_id] && burst_cnt < 4'(MAX_BURST)) begin
            take_vld  = 1'b1;
            take_id   = grant_id;
            burst_nxt = burst_cnt + 4'd1;
          end else if (win_vld) begin
            take_vld  = 1'b1;
            take_id   = win_id;
            burst_nxt = 4'd1;
            last_nxt  = win_id;
            grant_nxt = win_id;
            state_nxt = (MAX_BURST == 1) ? IDLE : BURST;
          end else begin
            state_nxt = IDLE;
          end
          data_nxt  = take_vld ? data_pad[{take_id, 3'b000} +: 8] : 8'hBC;
          valid_nxt = take_vld;
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = take_vld && (take_id == 3'(i));
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      slot_cnt   <= 3'd0;
      state      <= SYNC;
      sync_cnt   <= 4'd0;
      last_grant <= 3'(NUM_REQ - 1);
      burst_cnt  <= 4'd0;
      data_out   <= 8'hBC;
      valid_out  <= 1'b0;
      grant_id   <= 3'd0;
      link_up    <= 1'b0;
    end else begin
      slot_cnt   <= slot_cnt + 3'd1;
      state      <= state_nxt;
      sync_cnt   <= sync_nxt;
      last_grant <= last_nxt;
      burst_cnt  <= burst_nxt;
      data_out   <= data_nxt;
      valid_out  <= valid_nxt;
      grant_id   <= grant_nxt;
      link_up    <= link_nxt;
    end
  end

`ifdef TX_STATS_EN
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      tx_byte_count <= 16'h0000;
    end else if (take_vld && tx_byte_count != 16'hFFFF) begin
      tx_byte_count <= tx_byte_count + 16'd1;
    end
  end
`else
  assign tx_byte_count = 16'h0000;
`endif

endmodule

// File: doc/tx_lane_scheduler.md
Name: tx_lane_scheduler

Overview:
- Sequences the byte-to-serial transmitter; owns the byte-slot timing of that serializer.
- Runs on clk_32f: one byte slot = 8 clk_32f cycles, aligned to the serializer's bit index. Both blocks leave reset together, so slot boundaries coincide.
- After reset, sends a training run of COM (0xBC) idle bytes. Then shares the serializer among NUM_REQ byte-stream requesters with round-robin, burst-limited arbitration.
- Drives the serializer's data_in/valid_in directly; the serializer sends 0xBC whenever valid is low.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SYNC_BYTES, 4, COM bytes sent after reset before arbitration starts (1..15)
- MAX_BURST, 4, max consecutive bytes granted to one requester before forced re-arbitration (1..15)

Ports:
- clk_32f  input  1  bit clock of serializer
- reset_L  input  1  async active-low reset
- req_valid  input  NUM_REQ  requester i has a byte available
- req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_ready  output  NUM_REQ  one-hot pulse; byte of requester i consumed this cycle
- data_out  output  8  byte to serializer data_in
- valid_out  output  1  to serializer valid_in
- grant_id  output  3  requester that supplied current data_out
- link_up  output  1  training done, arbitration active
- tx_byte_count  output  16  bytes transmitted (see Optional Feature)

Behaviour:
- Reset/clock: one clock, clk_32f. reset_L is asynchronous and active-low.
- Reset values: slot_cnt=0, state=SYNC, data_out=8'hBC, valid_out=0, grant_id=0, link_up=0, last_grant=NUM_REQ-1, burst_cnt=0, tx_byte_count=0.
- Reset asserted mid-operation: everything returns to the values above at once. A byte being serialized is abandoned; no req_ready is issued.
- Slot counter: slot_cnt is 3 bits and increments every cycle, wrapping 7->0.
  - boundary = (slot_cnt==7).
  - data_out, valid_out and grant_id update only on a boundary edge and are held for the following 8 cycles.
- States: SYNC, IDLE, BURST. All transitions happen only on boundary edges.
- SYNC:
  - Outputs data_out=0xBC, valid_out=0. sync_cnt increments each boundary.
  - On the boundary where sync_cnt==SYNC_BYTES-1: go to IDLE and set link_up=1. link_up then stays high until reset.
  - req_ready is held 0.
- Winner selection (IDLE, or BURST when re-arbitrating):
  - Search from last_grant+1 upward, modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - When BURST re-arbitrates, the current holder is searched last.
- IDLE at boundary:
  - Winner w exists: data_out<=req_data[w], valid_out<=1, grant_id<=w, last_grant<=w, burst_cnt<=1. Next state is BURST, or stays IDLE if MAX_BURST==1.
  - No winner: data_out<=0xBC, valid_out<=0, grant_id unchanged.
- BURST at boundary:
  - req_valid[grant_id]=1 and burst_cnt<MAX_BURST: continue; take its byte, burst_cnt++.
  - Otherwise re-arbitrate. A winner restarts BURST with burst_cnt=1. No winner gives idle byte and state IDLE.
  - If the holder is the only valid requester after hitting MAX_BURST, it wins again. A single requester alone is never starved.
- req_ready:
  - Combinational: req_ready[i] = boundary && state!=SYNC && (i is the requester whose byte is taken at this edge).
  - At most one bit set; high for exactly one cycle per byte.
- Requester protocol:
  - Hold req_valid and req_data stable until the ready pulse.
  - A requester may drop valid only after ready; otherwise behaviour is undefined.
- Throughput and latency:
  - Max 1 byte per 8 cycles.
  - A byte sampled at boundary edge k sits on data_out for cycles k+1..k+8. The serializer shifts it MSB-first over those cycles.
- Simultaneous requests: resolved purely by the rotating pointer; no request is lost, it waits for a later boundary.

Optional Feature:
- Macro: TX_STATS_EN.
- Defined: tx_byte_count increments on every boundary edge where valid_out is loaded with 1, saturating at 16'hFFFF. COM/idle bytes are not counted. Cleared only by reset.
- Undefined: port present, tied to 16'h0000; no counter logic.

Test Plan:
- Training: release reset with all req_valid=0 -> valid_out=0 and data_out=0xBC; link_up rises at the boundary edge ending slot SYNC_BYTES (cycle 8*4=32 for defaults); no req_ready before then.
- Early request: req_valid[2]=1, data 0x5A from reset -> first ready pulse on req_ready[2] at the first boundary after link_up; data_out=0x5A, valid_out=1, grant_id=2, held 8 cycles.
- Round-robin: all four valid continuously, MAX_BURST=1 -> grant sequence 0,1,2,3,0..., one ready pulse per 8 cycles.
- Burst limit: req 0 and req 1 continuously valid, MAX_BURST=4 -> four bytes from 0, four from 1, alternating; with only req 0 valid -> uninterrupted stream from 0.
- Gap handling: req 3 drops valid after its 2nd byte -> next boundary gives 0xBC, valid_out=0, state IDLE.
- Mid-run reset: assert reset_L=0 at slot_cnt=3 during a burst -> outputs at reset values immediately, link_up=0, training restarts; with TX_STATS_EN, tx_byte_count=0 and 10 data bytes later reads 10.
